// File: rtl/av2_lf_pkg.sv
// Shared definitions for the AV2 loop-filter stream blocks: FSM encoding,
// tap shift, latched filter configuration and the pixel clip helper.
package av2_lf_pkg;

    localparam int unsigned STATE_W   = 3;
    localparam int unsigned CFG_W     = 3;
    localparam int unsigned TAP_SHIFT = 3;

    localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] ST_RUN   = 3'd1;
    localparam logic [STATE_W-1:0] ST_FLUSH = 3'd2;
    localparam logic [STATE_W-1:0] ST_DRAIN = 3'd3;
    localparam logic [STATE_W-1:0] ST_DONE  = 3'd4;

    typedef struct packed {
        logic [CFG_W-1:0] str;
        logic [CFG_W-1:0] damping;
    } cfg_t;

    // Saturate a signed value into the unsigned pixel range [0, 2^bit_depth-1].
    function automatic logic [31:0] clip_pixel(input logic signed [31:0] val,
                                               input int unsigned bit_depth);
        logic signed [31:0] max_v;
        max_v = $signed((32'd1 << bit_depth) - 32'd1);
        if (val < 32'sd0)
            clip_pixel = '0;
        else if (val > max_v)
            clip_pixel = max_v;
        else
            clip_pixel = val;
    endfunction

endpackage

// File: rtl/av2_cdef_tap.sv
// Combinational horizontal CDEF-style tap: damped neighbour differences,
// strength-scaled adjustment and clip back to the pixel range.
module av2_cdef_tap #(
    parameter int unsigned BIT_DEPTH = 10
) (
    input  logic [BIT_DEPTH-1:0] left_i,
    input  logic [BIT_DEPTH-1:0] cur_i,
    input  logic [BIT_DEPTH-1:0] right_i,
    input  logic                 left_vld_i,
    input  logic                 right_vld_i,
    input  logic [2:0]           str_i,
    input  logic [2:0]           damping_i,
    output logic [BIT_DEPTH-1:0] pixel_o
);
    import av2_lf_pkg::*;

    localparam int unsigned DW = BIT_DEPTH + 2;
    localparam int unsigned AW = BIT_DEPTH + 6;

    logic signed [DW-1:0] dl, dr, tl, tr;
    logic        [DW-1:0] abs_l, abs_r, thr;
    logic signed [AW-1:0] sum, str_w, prod, adj, val;

    always_comb begin
        dl      = $signed({2'b00, left_i})  - $signed({2'b00, cur_i});
        dr      = $signed({2'b00, right_i}) - $signed({2'b00, cur_i});
        abs_l   = dl[DW-1] ? $unsigned(-dl) : $unsigned(dl);
        abs_r   = dr[DW-1] ? $unsigned(-dr) : $unsigned(dr);
        thr     = DW'(1) << damping_i;
        // Absent neighbours and large steps (likely real edges) contribute nothing.
        tl      = (left_vld_i  && (abs_l <= thr)) ? dl : '0;
        tr      = (right_vld_i && (abs_r <= thr)) ? dr : '0;
        sum     = AW'(tl) + AW'(tr);
        str_w   = $signed({{(AW-CFG_W){1'b0}}, str_i});
        prod    = sum * str_w;
        adj     = prod >>> TAP_SHIFT;
        val     = $signed({{(AW-BIT_DEPTH){1'b0}}, cur_i}) + adj;
        pixel_o = BIT_DEPTH'(clip_pixel(32'(val), BIT_DEPTH));
    end

endmodule

// File: rtl/av2_cdef_stream_filter.sv
// Raster-order block filter: each pixel is output once its right neighbour
// arrives; a FLUSH cycle per row emits the last pixel. AV2_LF_STATS_EN adds mod_count.
module av2_cdef_stream_filter #(
    parameter int unsigned BLOCK_SIZE = 8,
    parameter int unsigned BIT_DEPTH  = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 is_chroma,
    input  logic [2:0]           strength_y,
    input  logic [2:0]           strength_uv,
    input  logic [2:0]           damping,
    input  logic [BIT_DEPTH-1:0] in_pixel,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [BIT_DEPTH-1:0] out_pixel,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic                 busy,
    output logic                 done
`ifdef AV2_LF_STATS_EN
   ,output logic [15:0]          mod_count
`endif
);
    import av2_lf_pkg::*;

    localparam int unsigned CNT_W = (BLOCK_SIZE > 2) ? $clog2(BLOCK_SIZE) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BLOCK_SIZE - 1);

    logic [STATE_W-1:0]   state_q, state_d;
    logic [CNT_W-1:0]     col_q, col_d, row_q, row_d;
    logic [BIT_DEPTH-1:0] cur_q, cur_d, left_q, left_d;
    cfg_t                 cfg_q, cfg_d;
    logic [BIT_DEPTH-1:0] pix_q, pix_d;
    logic                 vld_q, vld_d, last_q, last_d, done_q, done_d;
    logic [BIT_DEPTH-1:0] tap_pix;
    logic                 can_emit, xfer, emit;
`ifdef AV2_LF_STATS_EN
    logic [15:0]          cnt_q, cnt_d;
`endif

    // Right tap exists only in RUN; the left tap is missing for column 0 only.
    av2_cdef_tap #(.BIT_DEPTH(BIT_DEPTH)) u_tap (
        .left_i      (left_q),
        .cur_i       (cur_q),
        .right_i     (in_pixel),
        .left_vld_i  ((state_q == ST_FLUSH) || (col_q > CNT_W'(1))),
        .right_vld_i (state_q == ST_RUN),
        .str_i       (cfg_q.str),
        .damping_i   (cfg_q.damping),
        .pixel_o     (tap_pix)
    );

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        cur_d    = cur_q;
        left_d   = left_q;
        cfg_d    = cfg_q;
        pix_d    = pix_q;
        vld_d    = vld_q;
        last_d   = last_q;
        done_d   = 1'b0;
        emit     = 1'b0;
`ifdef AV2_LF_STATS_EN
        cnt_d    = cnt_q;
`endif
        can_emit = !vld_q || out_ready;
        in_ready = (state_q == ST_RUN) && can_emit;
        busy     = (state_q != ST_IDLE);
        xfer     = in_valid && in_ready;

        if (vld_q && out_ready) begin
            vld_d  = 1'b0;
            last_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cfg_d.str     = is_chroma ? strength_uv : strength_y;
                    cfg_d.damping = damping;
                    col_d         = '0;
                    row_d         = '0;
                    state_d       = ST_RUN;
`ifdef AV2_LF_STATS_EN
                    cnt_d         = '0;
`endif
                end
            end
            ST_RUN: begin
                if (xfer) begin
                    cur_d = in_pixel;
                    if (col_q != '0) begin
                        emit   = 1'b1;
                        last_d = 1'b0;
                        left_d = cur_q;
                    end
                    if (col_q == LAST_IDX)
                        state_d = ST_FLUSH;
                    else
                        col_d = col_q + CNT_W'(1);
                end
            end
            ST_FLUSH: begin
                if (can_emit) begin
                    emit   = 1'b1;
                    last_d = (row_q == LAST_IDX);
                    col_d  = '0;
                    if (row_q == LAST_IDX) begin
                        state_d = ST_DRAIN;
                    end else begin
                        row_d   = row_q + CNT_W'(1);
                        state_d = ST_RUN;
                    end
                end
            end
            ST_DRAIN: begin
                if (vld_q && out_ready && last_q) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        if (emit) begin
            pix_d = tap_pix;
            vld_d = 1'b1;
`ifdef AV2_LF_STATS_EN
            if (tap_pix != cur_q)
                cnt_d = cnt_q + 16'd1;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            col_q   <= '0;
            row_q   <= '0;
            cur_q   <= '0;
            left_q  <= '0;
            cfg_q   <= '0;
            pix_q   <= '0;
            vld_q   <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef AV2_LF_STATS_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            cur_q   <= cur_d;
            left_q  <= left_d;
            cfg_q   <= cfg_d;
            pix_q   <= pix_d;
            vld_q   <= vld_d;
            last_q  <= last_d;
            done_q  <= done_d;
`ifdef AV2_LF_STATS_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign out_pixel = pix_q;
    assign out_valid = vld_q;
    assign out_last  = last_q;
    assign done      = done_q;
`ifdef AV2_LF_STATS_EN
    assign mod_count = cnt_q;
`endif

endmodule

// File: tb/tb_av2_cdef_stream_filter.sv
// Randomized bench for av2_cdef_stream_filter against a per-block reference
// computed directly from the filter rules.
module tb_av2_cdef_stream_filter;

    localparam int BS   = 8;
    localparam int BD   = 10;
    localparam int NPIX = BS * BS;
    localparam int MAXV = (1 << BD) - 1;

    logic          clk, rst_n, start, is_chroma;
    logic [2:0]    strength_y, strength_uv, damping;
    logic [BD-1:0] in_pixel;
    logic          in_valid, in_ready;
    logic [BD-1:0] out_pixel;
    logic          out_valid, out_ready, out_last, busy, done;
`ifdef AV2_LF_STATS_EN
    logic [15:0]   mod_count;
`endif

    av2_cdef_stream_filter #(.BLOCK_SIZE(BS), .BIT_DEPTH(BD)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .is_chroma(is_chroma),
        .strength_y(strength_y), .strength_uv(strength_uv), .damping(damping),
        .in_pixel(in_pixel), .in_valid(in_valid), .in_ready(in_ready),
        .out_pixel(out_pixel), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy), .done(done)
`ifdef AV2_LF_STATS_EN
       ,.mod_count(mod_count)
`endif
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int c0    = 0;
    int last_hs_cyc = 0;
    int hold_cnt = 0;
    bit rnd_ready = 0;
    int exp_mod = 0;
    int blk[NPIX];
    int exp_pix[$];
    bit exp_last[$];
    int out_log[$];
    bit exp_done_next = 0;
    bit prev_stall = 0;
    int prev_pix = 0;
    bit prev_last = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference tap from the written rules: damped differences, floor shift, clip.
    function automatic int ref_pix(int l, int c, int r, bit lv, bit rv, int s, int d);
        int dl, dr, sum, adj, v;
        dl = lv ? (l - c) : 0;
        dr = rv ? (r - c) : 0;
        if (dl > (1 << d) || -dl > (1 << d)) dl = 0;
        if (dr > (1 << d) || -dr > (1 << d)) dr = 0;
        sum = (dl + dr) * s;
        adj = (sum >= 0) ? (sum / 8) : -((-sum + 7) / 8);
        v = c + adj;
        if (v < 0) v = 0;
        if (v > MAXV) v = MAXV;
        return v;
    endfunction

    function automatic void build_expected(int s, int d);
        int v;
        exp_pix.delete();
        exp_last.delete();
        exp_mod = 0;
        for (int r = 0; r < BS; r++) begin
            for (int c = 0; c < BS; c++) begin
                v = ref_pix((c > 0) ? blk[r*BS+c-1] : 0, blk[r*BS+c],
                            (c < BS-1) ? blk[r*BS+c+1] : 0, c > 0, c < BS-1, s, d);
                exp_pix.push_back(v);
                exp_last.push_back((r == BS-1) && (c == BS-1));
                if (v != blk[r*BS+c]) exp_mod++;
            end
        end
    endfunction

    // Output monitor: beat order/value, hold-while-stalled, backpressure, done timing.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("done_pulse", 32'(done), 32'(exp_done_next));
            exp_done_next = 0;
            if (prev_stall) begin
                chk("hold_valid", 32'(out_valid), 1);
                chk("hold_pixel", 32'(out_pixel), 32'(prev_pix));
                chk("hold_last", 32'(out_last), 32'(prev_last));
            end
            if (out_valid && !out_ready)
                chk("in_ready_stall", 32'(in_ready), 0);
            if (out_valid && out_ready) begin
                if (exp_pix.size() == 0) begin
                    chk("unexpected_beat", 1, 0);
                end else begin
                    chk("beat_pixel", 32'(out_pixel), 32'(exp_pix.pop_front()));
                    chk("beat_last", 32'(out_last), 32'(exp_last.pop_front()));
                end
                out_log.push_back(int'(out_pixel));
                if (out_last) begin
                    exp_done_next = 1;
                    last_hs_cyc = cyc + 1;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_pix   = int'(out_pixel);
            prev_last  = out_last;
        end else begin
            prev_stall = 0;
            exp_done_next = 0;
        end
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (hold_cnt > 0) begin
                out_ready = 1'b0;
                hold_cnt--;
            end else begin
                out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 0);
        chk({tag, "_out_valid"}, 32'(out_valid), 0);
        chk({tag, "_out_last"}, 32'(out_last), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_out_pixel"}, 32'(out_pixel), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        start = 1'b0;
        hold_cnt = 0;
        @(negedge clk);
        check_reset_outputs("midrst");
        exp_pix.delete();
        exp_last.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // Called at posedge+1; returns at posedge+1 with the DUT idle.
    task automatic run_block(input bit chroma, input int sy, input int suv, input int dmp,
                             input int gap_pct, input int abort_at, input int hold_at,
                             input int busy_start_at);
        int idx, guard, hold_pt;
        build_expected(chroma ? suv : sy, dmp);
        out_log.delete();
        hold_pt     = hold_at;
        start       = 1'b1;
        is_chroma   = chroma;
        strength_y  = 3'(sy);
        strength_uv = 3'(suv);
        damping     = 3'(dmp);
        @(posedge clk); #1;
        start = 1'b0;
        c0 = cyc;
        strength_y  = 3'($urandom);
        strength_uv = 3'($urandom);
        damping     = 3'($urandom);
        is_chroma   = 1'($urandom);
        idx = 0;
        guard = 0;
        while (idx < NPIX) begin
            if (idx == abort_at) begin
                do_reset();
                return;
            end
            in_pixel = BD'(blk[idx]);
            in_valid = ($urandom_range(0, 99) >= gap_pct);
            start    = (idx == busy_start_at);
            if (idx == hold_pt) begin
                hold_cnt = 10;
                hold_pt = -1;
            end
            @(negedge clk);
            if (guard == 0) chk("busy_run", 32'(busy), 1);
            if (in_valid && in_ready) idx++;
            @(posedge clk); #1;
            guard++;
            if (guard > 5000) begin
                chk("input_timeout", 32'(idx), 32'(NPIX));
                break;
            end
        end
        in_valid = 1'b0;
        start = 1'b0;
        guard = 0;
        @(negedge clk);
        while (!done && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        chk("done_seen", 32'(done), 1);
        chk("queue_drained", 32'(exp_pix.size()), 0);
        chk("beat_count", 32'(out_log.size()), 32'(NPIX));
`ifdef AV2_LF_STATS_EN
        chk("mod_count", 32'(mod_count), 32'(exp_mod));
`endif
        @(negedge clk);
        chk("busy_idle", 32'(busy), 0);
        @(posedge clk); #1;
    endtask

    function automatic int count_diff_from_input();
        int n = 0;
        for (int i = 0; i < NPIX; i++)
            if (i >= out_log.size() || out_log[i] != blk[i]) n++;
        return n;
    endfunction

    initial begin
        rst_n = 1'b0; start = 1'b0; is_chroma = 1'b0;
        strength_y = '0; strength_uv = '0; damping = '0;
        in_pixel = '0; in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        chk("ref_pin_edge", 32'(ref_pix(0, 100, 200, 0, 1, 4, 7)), 150);
        chk("ref_pin_mid", 32'(ref_pix(100, 200, 100, 1, 1, 4, 7)), 100);
        chk("ref_pin_damp", 32'(ref_pix(0, 100, 200, 0, 1, 4, 5)), 100);
        chk("ref_pin_clip", 32'(ref_pix(1023, 1000, 1023, 1, 1, 7, 7)), 1023);
        chk("ref_pin_floor", 32'(ref_pix(0, 1023, 1000, 0, 1, 7, 7)), 1002);

        // str=0 passthrough at full rate: exact timing of the last beat
        for (int i = 0; i < NPIX; i++) blk[i] = int'($urandom_range(0, MAXV));
        rnd_ready = 0;
        run_block(0, 0, 5, 3, 0, -1, -1, -1);
        chk("passthru_str0", 32'(count_diff_from_input()), 0);
        chk("last_beat_cycle", 32'(last_hs_cyc - c0), 32'(9*BS + 1));

        // Alternating row, strong filter
        for (int i = 0; i < NPIX; i++) blk[i] = (i % 2 == 0) ? 100 : 200;
        rnd_ready = 1;
        run_block(0, 4, 0, 7, 20, -1, -1, -1);
        chk("alt_pix0", 32'(out_log[0]), 150);
        chk("alt_pix1", 32'(out_log[1]), 100);

        // Same row, chroma strength, taps damped away
        run_block(1, 0, 4, 5, 20, -1, -1, -1);
        chk("damped_passthru", 32'(count_diff_from_input()), 0);

        // Clipping at the top of the range
        for (int i = 0; i < NPIX; i++) blk[i] = MAXV;
        blk[1] = 1000;
        run_block(0, 7, 0, 7, 10, -1, -1, -1);
        chk("clip_high", 32'(out_log[1]), 1023);
        chk("floor_neg", 32'(out_log[0]), 1002);

        for (int i = 0; i < NPIX; i++) blk[i] = 0;
        run_block(0, 7, 7, 7, 10, -1, -1, -1);
        chk("zero_block", 32'(count_diff_from_input()), 0);

        // Long stall mid-row plus a start pulse while busy
        for (int i = 0; i < NPIX; i++) blk[i] = int'($urandom_range(0, MAXV));
        run_block(0, 6, 2, 6, 15, -1, 20, 35);

        // Reset part-way through a block, then a fresh block
        run_block(1, 3, 5, 7, 10, 30, -1, -1);
        for (int i = 0; i < NPIX; i++) blk[i] = int'($urandom_range(0, MAXV));
        run_block(1, 3, 5, 7, 10, -1, -1, -1);

        for (int b = 0; b < 6; b++) begin
            for (int i = 0; i < NPIX; i++)
                blk[i] = (b % 2 == 0) ? int'($urandom_range(0, MAXV))
                                      : int'($urandom_range(400, 480));
            run_block(1'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                      int'($urandom_range(0, 7)), int'($urandom_range(0, 40)), -1,
                      (b == 3) ? 12 : -1, (b == 4) ? 50 : -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
